// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared pipeline-control encodings and hazard priority resolution
package hazard_control_unit_pkg;

  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_MEM_WAIT = 2'd1;
  localparam logic [1:0]  ST_HALT     = 2'd2;
  localparam logic [4:0]  REG_ZERO    = 5'd0;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctrl_t;

  // A taken branch beats load-use because the ID instruction is wrong-path anyway.
  function automatic ctrl_t run_ctrl(input logic mem_stall, input logic branch,
                                     input logic load_use);
    ctrl_t c;
    c.pc_write     = 1'b1;
    c.if_id_write  = 1'b1;
    c.if_id_flush  = 1'b0;
    c.id_ex_write  = 1'b1;
    c.id_ex_flush  = 1'b0;
    c.ex_mem_write = 1'b1;
    c.mem_wb_flush = 1'b0;
    if (mem_stall) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_write  = 1'b0;
      c.ex_mem_write = 1'b0;
      c.mem_wb_flush = 1'b1;
    end else if (branch) begin
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_flush  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// rtl/hazard_control_unit_sat_counter.sv - saturating up-counter for performance statistics
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch / data-memory-wait pipeline sequencer
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_MemRead,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            load_use, mem_stall;
  ctrl_t           ctrl;

  assign load_use = ex_MemRead && (ex_rd_addr != REG_ZERO) &&
                    ((id_uses_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                     (id_uses_rs2 && (ex_rd_addr == id_rs2_addr)));
  // A dropped request while waiting counts as completion, so both reduce to this.
  assign mem_stall = mem_req && !dmem_ready;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    ctrl    = run_ctrl(mem_stall, ex_branch_taken, load_use);
    case (state_q)
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == TO_W'(MEM_TIMEOUT - 1)) state_d = ST_HALT;
        end else begin
          tcnt_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        ctrl = '0;
      end
      default: begin
        state_d = mem_stall ? ST_MEM_WAIT : ST_RUN;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Reset forces every stage to hold a NOP regardless of the registered state.
  assign pc_write     = rst_n && ctrl.pc_write;
  assign if_id_write  = rst_n && ctrl.if_id_write;
  assign id_ex_write  = rst_n && ctrl.id_ex_write;
  assign ex_mem_write = rst_n && ctrl.ex_mem_write;
  assign if_id_flush  = !rst_n || ctrl.if_id_flush;
  assign id_ex_flush  = !rst_n || ctrl.id_ex_flush;
  assign mem_wb_flush = !rst_n || ctrl.mem_wb_flush;
  assign halted       = (state_q == ST_HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != ST_HALT) && !ctrl.pc_write),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit with a behavioural model
module tb_hazard_control_unit;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // {pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f, halted}
  localparam logic [7:0] C_RST  = 8'b0010_1010;
  localparam logic [7:0] C_FRZ  = 8'b0000_0010;
  localparam logic [7:0] C_HALT = 8'b0000_0001;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_LU   = 8'b0001_1100;
  localparam logic [7:0] C_NONE = 8'b1101_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_MemRead = 1'b0;
  logic          ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b1;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, mem_wb_flush, halted;
  logic [CW-1:0] stall_cycles;

  hazard_control_unit #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_MemRead(ex_MemRead),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [7:0]    ctrl;
    logic [CW-1:0] stall;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0, bad = 0, cyc = 0;

  // Model state: stall count, length of the current unbroken memory stall, halt flag.
  int m_cnt = 0, m_consec = 0;
  bit m_halt = 0;

  task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mreq, input logic rdy);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n = rst; id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd_addr = rd; ex_MemRead = mr; ex_branch_taken = br; mem_req = mreq; dmem_ready = rdy;
    cyc++;
    e.cyc = cyc;
    if (!rst) begin
      e.ctrl = C_RST; e.stall = '0;
      m_cnt = 0; m_consec = 0; m_halt = 0;
    end else begin
      e.stall = CW'(m_cnt);
      lu = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
      if (m_halt) begin
        e.ctrl = C_HALT;
      end else begin
        if (mreq && !rdy) begin
          e.ctrl = C_FRZ;
          m_consec++;
          if (m_consec == TO + 1) m_halt = 1;
        end else begin
          m_consec = 0;
          e.ctrl = br ? C_BR : (lu ? C_LU : C_NONE);
        end
        if (!e.ctrl[7] && m_cnt < CMAX) m_cnt++;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 1);
  endtask

  task automatic mem_wait(input int n, input logic br);
    for (int i = 0; i < n; i++) drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, br, 1, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      total++;
      if ({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted} !== me.ctrl) begin
        bad++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b", me.cyc,
                 {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                  ex_mem_write, mem_wb_flush, halted}, me.ctrl);
      end
      total++;
      if (stall_cycles !== me.stall) begin
        bad++;
        $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", me.cyc, stall_cycles, me.stall);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0);
    // load-use on rs1: one bubble
    drive(1, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 1);
    drive(1, 5'd5, 5'd1, 1, 1, 5'd0, 0, 0, 0, 1);
    idle(1);
    // load to x0, and unused rs2 match: no stall
    drive(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 1);
    drive(1, 5'd7, 5'd5, 1, 0, 5'd5, 1, 0, 0, 1);
    // branch with concurrent load-use: flush, no bubble
    drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 1);
    idle(1);
    // three frozen cycles with a pending branch, release with branch acted on
    mem_wait(3, 1);
    drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 1);
    idle(1);
    // request dropped while waiting counts as completion
    mem_wait(2, 0);
    idle(2);
    // timeout into HALT, stays halted whatever the inputs
    mem_wait(8, 0);
    drive(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 1);
    idle(2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // reset in the middle of a memory wait
    mem_wait(2, 0);
    drive(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 0, 1, 0);
    idle(2);
    // 20 load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) drive(1, 5'd9, 5'd1, 1, 0, 5'd9, 1, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) != 0, 5'($urandom % 4), 5'($urandom % 4),
            1'($urandom), 1'($urandom), 5'($urandom % 4), 1'($urandom),
            ($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 3) != 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
